// File: rtl/fpu_round.sv
// Final rounding stage of the FPU: turns a 35-bit unrounded extended result
// into an IEEE-754 single plus {NV,DZ,OF,UF,NX}, in a two-stage valid/ready pipeline.
module fpu_round #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [34:0]      in_data,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Input field split
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic        in_g, in_r, in_s;

    assign in_sign = in_data[34];
    assign in_exp  = in_data[33:26];
    assign in_frac = in_data[25:3];
    assign in_g    = in_data[2];
    assign in_r    = in_data[1];
    assign in_s    = in_data[0];

    // Stage 1 decode
    logic dec_special, dec_nan, dec_snan, dec_inexact, dec_tiny, dec_inc;

    always_comb begin
        dec_special = (in_exp == 8'hFF);
        dec_nan     = dec_special && (in_frac != 23'd0);
        dec_snan    = dec_nan && !in_frac[22];
        dec_inexact = in_g | in_r | in_s;
        dec_tiny    = (in_exp == 8'd0) && dec_inexact;
        dec_inc     = 1'b0;
        case (in_rm)
            RM_RTZ:  dec_inc = 1'b0;
            RM_RDN:  dec_inc = in_sign & dec_inexact;
            RM_RUP:  dec_inc = !in_sign & dec_inexact;
            RM_RMM:  dec_inc = in_g;
            default: dec_inc = in_g & (in_r | in_s | in_frac[0]);
        endcase
    end

    // Pipeline control: both stages move together whenever the output slot frees up
    logic s1_valid_reg, s2_valid_reg;
    logic advance;

    assign advance  = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || advance;

    logic             s1_sign_reg, s1_inc_reg, s1_inexact_reg, s1_tiny_reg;
    logic             s1_special_reg, s1_nan_reg, s1_snan_reg;
    logic [7:0]       s1_exp_reg;
    logic [22:0]      s1_frac_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_sign_reg    <= in_sign;
            s1_exp_reg     <= in_exp;
            s1_frac_reg    <= in_frac;
            s1_inc_reg     <= dec_inc;
            s1_inexact_reg <= dec_inexact;
            s1_tiny_reg    <= dec_tiny;
            s1_special_reg <= dec_special;
            s1_nan_reg     <= dec_nan;
            s1_snan_reg    <= dec_snan;
            s1_tag_reg     <= in_tag;
        end
    end

    // Stage 2: increment on the joint exponent/fraction magnitude so carries roll into the exponent
    logic [30:0] sum;
    logic        sum_ovf;
    logic [31:0] res_next;
    logic [4:0]  flags_next;

    always_comb begin
        sum        = {s1_exp_reg, s1_frac_reg} + {30'd0, s1_inc_reg};
        sum_ovf    = (sum[30:23] == 8'hFF);
        res_next   = {s1_sign_reg, sum};
        flags_next = {2'b00, sum_ovf, s1_tiny_reg, s1_inexact_reg | sum_ovf};
        if (s1_special_reg) begin
            if (s1_nan_reg) begin
                res_next   = 32'h7FC0_0000;
                flags_next = {s1_snan_reg, 4'b0000};
            end else begin
                res_next   = {s1_sign_reg, 8'hFF, 23'd0};
                flags_next = 5'b00000;
            end
        end
    end

    logic [31:0]      s2_data_reg;
    logic [4:0]       s2_flags_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= 32'd0;
            s2_flags_reg <= 5'd0;
            s2_tag_reg   <= '0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg  <= res_next;
                s2_flags_reg <= flags_next;
                s2_tag_reg   <= s1_tag_reg;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_flags = s2_flags_reg;
    assign out_tag   = s2_tag_reg;

endmodule
